// File: rtl/keypad_lock.sv
// Keypad code lock: collects CODE_LEN strobed digits, compares against a programmable code,
// unlocks with auto-relock timeout, and enters a timed lockout after MAX_FAIL mismatches.
module keypad_lock #(
    parameter int unsigned DIGIT_W                       = 4,
    parameter int unsigned CODE_LEN                      = 4,
    parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE  = 16'h1234,
    parameter int unsigned MAX_FAIL                      = 3,
    parameter int unsigned UNLOCK_CYC                    = 500,
    parameter int unsigned LOCKOUT_CYC                   = 1000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            key_valid,
    input  logic [DIGIT_W-1:0]              key_digit,
    input  logic                            relock,
    input  logic                            prog_req,
    output logic                            locked,
    output logic                            unlocked,
    output logic                            error,
    output logic                            lockout,
    output logic                            prog_mode,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

    localparam int unsigned CODE_W  = DIGIT_W * CODE_LEN;
    localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int unsigned TMAX    = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int unsigned TIMER_W = $clog2(TMAX + 1);
    localparam int unsigned IDX_W   = $clog2(CODE_LEN + 1);

    localparam logic [TIMER_W-1:0] UNLOCK_LAST  = TIMER_W'(UNLOCK_CYC - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LAST = TIMER_W'(LOCKOUT_CYC - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0]  FAIL_MAX     = FAIL_W'(MAX_FAIL);

    typedef enum logic [2:0] {
        StEntry,
        StCheck,
        StUnlocked,
        StProg,
        StLockout
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CODE_W-1:0]    entry_q, entry_d;
    logic [CODE_W-1:0]    shadow_q, shadow_d;
    logic [CODE_W-1:0]    code_q, code_d;
    logic [FAIL_W-1:0]    fail_q, fail_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 error_q, error_d;
    logic [FAIL_W-1:0]    fail_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StEntry;
            idx_q    <= '0;
            entry_q  <= '0;
            shadow_q <= '0;
            code_q   <= DEFAULT_CODE;
            fail_q   <= '0;
            timer_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            entry_q  <= entry_d;
            shadow_q <= shadow_d;
            code_q   <= code_d;
            fail_q   <= fail_d;
            timer_q  <= timer_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        entry_d  = entry_q;
        shadow_d = shadow_q;
        code_d   = code_q;
        fail_d   = fail_q;
        timer_d  = timer_q;
        error_d  = 1'b0;
        fail_inc = (fail_q == FAIL_MAX) ? fail_q : fail_q + 1'b1;

        unique case (state_q)
            StEntry: begin
                if (relock) begin
                    idx_d = '0;
                end else if (key_valid) begin
                    // MSD is entered first, so older digits move up
                    entry_d = (entry_q << DIGIT_W) | CODE_W'(key_digit);
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = StCheck;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StCheck: begin
                if (entry_q == code_q) begin
                    state_d = StUnlocked;
                    fail_d  = '0;
                    timer_d = '0;
                end else begin
                    error_d = 1'b1;
                    fail_d  = fail_inc;
                    if (fail_inc == FAIL_MAX) begin
                        state_d = StLockout;
                        timer_d = '0;
                    end else begin
                        state_d = StEntry;
                    end
                end
            end
            StUnlocked: begin
                if (relock) begin
                    state_d = StEntry;
                end else if (timer_q == UNLOCK_LAST) begin
                    state_d = StEntry;
                end else if (prog_req) begin
                    state_d = StProg;
                    idx_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StProg: begin
                if (relock) begin
                    state_d = StEntry;
                    idx_d   = '0;
                end else if (key_valid) begin
                    shadow_d = (shadow_q << DIGIT_W) | CODE_W'(key_digit);
                    if (idx_q == IDX_LAST) begin
                        code_d  = shadow_d;
                        idx_d   = '0;
                        timer_d = '0;
                        state_d = StUnlocked;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StLockout: begin
                if (timer_q == LOCKOUT_LAST) begin
                    state_d = StEntry;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = StEntry;
                idx_d   = '0;
            end
        endcase
    end

    assign unlocked  = (state_q == StUnlocked) || (state_q == StProg);
    assign locked    = ~unlocked;
    assign lockout   = (state_q == StLockout);
    assign prog_mode = (state_q == StProg);
    assign error     = error_q;
    assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_keypad_lock.sv
// Bench for keypad_lock: digit-queue reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic.
module tb_keypad_lock;

    localparam int CL = 4;
    localparam int MF = 3;
    localparam int UC = 500;
    localparam int LC = 1000;

    localparam int M_ENTRY = 0;
    localparam int M_CHECK = 1;
    localparam int M_UNL   = 2;
    localparam int M_PROG  = 3;
    localparam int M_LOCK  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = '0;
    logic       relock = 1'b0;
    logic       prog_req = 1'b0;
    logic       locked, unlocked, error, lockout, prog_mode;
    logic [1:0] fail_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: mode, digits typed so far, remaining cycles in timed modes
    int m_mode = M_ENTRY;
    int m_entry[$];
    int m_prog[$];
    int m_code[CL];
    int m_fails = 0;
    int m_left = 0;
    bit m_err = 1'b0;
    bit chk_en = 1'b0;

    keypad_lock dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .relock    (relock),
        .prog_req  (prog_req),
        .locked    (locked),
        .unlocked  (unlocked),
        .error     (error),
        .lockout   (lockout),
        .prog_mode (prog_mode),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit kv, input int kd, input bit rl,
                              input bit pr);
        bit ok;
        m_err = 1'b0;
        if (r) begin
            m_mode = M_ENTRY;
            m_entry.delete();
            m_prog.delete();
            m_code = '{1, 2, 3, 4};
            m_fails = 0;
            m_left = 0;
            return;
        end
        case (m_mode)
            M_ENTRY: begin
                if (rl) m_entry.delete();
                else if (kv) begin
                    m_entry.push_back(kd);
                    if (m_entry.size() == CL) m_mode = M_CHECK;
                end
            end
            M_CHECK: begin
                ok = 1'b1;
                for (int i = 0; i < CL; i++) if (m_entry[i] != m_code[i]) ok = 1'b0;
                m_entry.delete();
                if (ok) begin
                    m_mode = M_UNL;
                    m_fails = 0;
                    m_left = UC;
                end else begin
                    m_err = 1'b1;
                    if (m_fails < MF) m_fails++;
                    if (m_fails == MF) begin
                        m_mode = M_LOCK;
                        m_left = LC;
                    end else m_mode = M_ENTRY;
                end
            end
            M_UNL: begin
                if (rl || m_left == 1) m_mode = M_ENTRY;
                else if (pr) begin
                    m_mode = M_PROG;
                    m_prog.delete();
                end else m_left--;
            end
            M_PROG: begin
                if (rl) m_mode = M_ENTRY;
                else if (kv) begin
                    m_prog.push_back(kd);
                    if (m_prog.size() == CL) begin
                        for (int i = 0; i < CL; i++) m_code[i] = m_prog[i];
                        m_mode = M_UNL;
                        m_left = UC;
                    end
                end
            end
            default: begin
                if (m_left == 1) begin
                    m_mode = M_ENTRY;
                    m_fails = 0;
                end else m_left--;
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("locked", int'(locked), int'(!(m_mode == M_UNL || m_mode == M_PROG)));
            check("unlocked", int'(unlocked), int'(m_mode == M_UNL || m_mode == M_PROG));
            check("error", int'(error), int'(m_err));
            check("lockout", int'(lockout), int'(m_mode == M_LOCK));
            check("prog_mode", int'(prog_mode), int'(m_mode == M_PROG));
            check("fail_cnt", int'(fail_cnt), m_fails);
        end
    end

    task automatic tick(input bit r, input bit kv, input int kd, input bit rl, input bit pr);
        rst = r;
        key_valid = kv;
        key_digit = kd[3:0];
        relock = rl;
        prog_req = pr;
        @(posedge clk);
        model_step(r, kv, kd, rl, pr);
        #1;
        rst = 1'b0;
        key_valid = 1'b0;
        relock = 1'b0;
        prog_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic key(input int d);
        tick(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic keys4(input int a, input int b, input int c, input int d);
        key(a);
        key(b);
        key(c);
        key(d);
    endtask

    task automatic do_rl();
        tick(1'b0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic do_pr();
        tick(1'b0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic do_rst();
        tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int op;
        do_rst();
        chk_en = 1'b1;
        check("lit_rst_locked", int'(locked), 1);
        check("lit_rst_fail", int'(fail_cnt), 0);

        // Correct code, unlock two cycles after last strobe, auto-relock after UC cycles
        keys4(1, 2, 3, 4);
        check("lit_check_cycle_locked", int'(locked), 1);
        idle(1);
        check("lit_unlock_n2", int'(unlocked), 1);
        check("lit_unlock_noerr", int'(error), 0);
        idle(UC - 1);
        check("lit_unlock_last_cycle", int'(unlocked), 1);
        idle(1);
        check("lit_autorelock", int'(locked), 1);

        // Three mismatches then lockout of exactly LC cycles
        for (int i = 1; i <= MF; i++) begin
            keys4(1, 2, 3, 5);
            idle(1);
            check("lit_err_pulse", int'(error), 1);
            check("lit_fail_cnt", int'(fail_cnt), i);
        end
        check("lit_lockout_on", int'(lockout), 1);
        for (int i = 0; i < LC - 1; i++)
            tick(1'b0, 1'b1, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        check("lit_lockout_last", int'(lockout), 1);
        idle(1);
        check("lit_lockout_off", int'(lockout), 0);
        check("lit_lockout_fail_clr", int'(fail_cnt), 0);
        keys4(1, 2, 3, 4);
        idle(1);
        check("lit_unlock_after_lockout", int'(unlocked), 1);

        // Reprogram to 9876
        do_pr();
        check("lit_prog_mode", int'(prog_mode), 1);
        keys4(9, 8, 7, 6);
        check("lit_prog_done", int'(prog_mode), 0);
        check("lit_prog_unlocked", int'(unlocked), 1);
        do_rl();
        keys4(1, 2, 3, 4);
        idle(1);
        check("lit_old_code_err", int'(error), 1);
        keys4(9, 8, 7, 6);
        idle(1);
        check("lit_new_code_unl", int'(unlocked), 1);
        do_rst();
        keys4(1, 2, 3, 4);
        idle(1);
        check("lit_default_after_rst", int'(unlocked), 1);

        // Relock mid-entry, aborted PROG keeps the code
        do_rl();
        key(1);
        key(2);
        do_rl();
        keys4(1, 2, 3, 4);
        idle(1);
        check("lit_partial_cleared", int'(unlocked), 1);
        do_pr();
        key(5);
        key(5);
        do_rl();
        check("lit_prog_abort", int'(locked), 1);
        keys4(1, 2, 3, 4);
        idle(1);
        check("lit_code_kept", int'(unlocked), 1);

        // relock beats prog_req; expiry beats prog_req
        tick(1'b0, 1'b0, 0, 1'b1, 1'b1);
        check("lit_relock_prio", int'(prog_mode), 0);
        keys4(1, 2, 3, 4);
        idle(1);
        idle(UC - 1);
        do_pr();
        check("lit_expiry_prio", int'(locked), 1);

        // A match clears fail_cnt; reset clears the index
        keys4(1, 2, 3, 5);
        idle(1);
        keys4(1, 2, 3, 4);
        idle(1);
        check("lit_match_clears_fail", int'(fail_cnt), 0);
        do_rl();
        key(1);
        key(2);
        do_rst();
        keys4(3, 4, 1, 2);
        idle(1);
        check("lit_rst_clears_idx", int'(error), 1);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            op = int'($urandom_range(0, 99));
            if (op < 35) begin
                for (int i = 0; i < CL; i++) begin
                    key(m_code[i]);
                    if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                end
                idle(int'($urandom_range(1, 4)));
            end else if (op < 55) begin
                keys4(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end else if (op < 65) begin
                do_rl();
            end else if (op < 78) begin
                do_pr();
                for (int i = 0; i < CL; i++) key(int'($urandom_range(0, 15)));
            end else if (op < 80) begin
                do_rst();
            end else if (op < 90) begin
                for (int i = 0; i < 12; i++)
                    tick(1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, 15)), 1'($urandom_range(0, 7) == 0),
                         1'($urandom_range(0, 7) == 0));
            end else begin
                idle(int'($urandom_range(1, 40)));
            end
        end
        idle(2);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_lock.md
Name: keypad_lock

Overview:
- Parametrised successor to the 8-bit sequence door lock.
- Accepts a strobed sequence of CODE_LEN keypad digits and compares it against a run-time programmable code.
- Unlocks on a match and auto-relocks after a timeout.
- Counts consecutive failures and enters a timed lockout. Sits between the keypad debouncer/encoder and the door actuator/LED drivers.

Parameters:
- DIGIT_W, 4, bits per keypad digit.
- CODE_LEN, 4, digits per code (must be ≥1).
- DEFAULT_CODE, 16'h1234, code after reset; width DIGIT_W*CODE_LEN; first digit entered = most-significant digit.
- MAX_FAIL, 3, consecutive mismatches that trigger lockout (must be ≥1).
- UNLOCK_CYC, 500, cycles spent unlocked before auto-relock.
- LOCKOUT_CYC, 1000, cycles spent in lockout.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_digit is valid this cycle.
- key_digit  in  DIGIT_W  digit value.
- relock  in  1  manual relock / clear-entry request.
- prog_req  in  1  request to reprogram the code (honoured only while unlocked).
- locked  out  1  high unless the state is UNLOCKED or PROG.
- unlocked  out  1  equals ~locked.
- error  out  1  one-cycle pulse on a code mismatch.
- lockout  out  1  high while in LOCKOUT.
- prog_mode  out  1  high while in PROG.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive mismatch count.

Behaviour:
- Reset is synchronous: rst high at an edge forces state=ENTRY, digit index=0, code=DEFAULT_CODE, fail_cnt=0, timer=0, locked=1, unlocked=0, error=0, lockout=0, prog_mode=0. Reset mid-operation discards any programmed code.
- All outputs are registered. locked, unlocked, lockout and prog_mode are decoded from the registered state.
- ENTRY:
  - Each key_valid shifts key_digit into the entry register (MSD first) and increments the index.
  - On accepting digit CODE_LEN (edge N), go to CHECK and reset the index to 0.
  - relock clears the index and stays in ENTRY.
- CHECK (one cycle; key_valid ignored):
  - Match: go to UNLOCKED, clear fail_cnt and the timer. unlocked=1 from cycle N+2.
  - Mismatch: pulse error at N+2 and increment fail_cnt. If the new fail_cnt equals MAX_FAIL, go to LOCKOUT with timer=0; otherwise return to ENTRY.
- UNLOCKED:
  - The timer counts each cycle. The state is held for exactly UNLOCK_CYC cycles, then returns to ENTRY.
  - relock returns to ENTRY immediately.
  - prog_req goes to PROG with index=0.
  - key_valid is ignored.
- PROG:
  - Digits shift into a shadow register.
  - After digit CODE_LEN, the shadow copies into the code register in the same edge; go to UNLOCKED with timer=0.
  - relock aborts to ENTRY and leaves the code unchanged.
  - No timeout applies in PROG.
- LOCKOUT:
  - All key_valid, relock and prog_req are ignored.
  - The state is held for exactly LOCKOUT_CYC cycles, then goes to ENTRY with fail_cnt=0.
- Simultaneous events in UNLOCKED: priority is relock > timer expiry > prog_req.
- fail_cnt saturates at MAX_FAIL. Only a successful match or the end of lockout clears it.
- Timer width is $clog2(max(UNLOCK_CYC,LOCKOUT_CYC)+1); the timer never wraps.
- Partial entries persist indefinitely; ENTRY has no inter-digit timeout.

Test Plan:
- Defaults, reset, then key 1,2,3,4 on consecutive cycles → unlocked=1 two cycles after the digit 4 strobe, error never asserted, fail_cnt=0. After 500 cycles → locked=1.
- Key 1,2,3,5 three times → three error pulses, fail_cnt 1→2→3, lockout=1 for exactly 1000 cycles. Digits keyed during lockout are ignored. Afterwards fail_cnt=0, and 1,2,3,4 unlocks.
- Unlock, pulse prog_req, key 9,8,7,6 → prog_mode high then low, unlocked stays 1. relock; 1,2,3,4 → error; 9,8,7,6 → unlocked. Then rst, and 1,2,3,4 unlocks again (code back to DEFAULT_CODE).
- Key 1,2 then relock, then 1,2,3,4 → unlocks with no error. During PROG, key 5,5 then relock → code remains 1234.
- Unlocked with relock and prog_req in the same cycle → ENTRY, prog_mode stays 0. prog_req on the cycle of timer expiry → ENTRY.
- Key 1,2,3,5 (fail_cnt=1), then 1,2,3,4 → unlocked and fail_cnt=0. Asserting rst mid-entry after 1,2 → index cleared, and 3,4,1,2 gives a mismatch error.
